// File: rtl/rename_if.sv
// rename_if: decode, issue and commit handshake bundle for rename_unit.
interface rename_if #(parameter int WIDTH = 2, parameter int PW = 6);
  logic in_valid, in_ready;
  logic [WIDTH-1:0] in_inst_valid;
  logic [WIDTH*5-1:0] in_src1, in_src2, in_dst;
  logic out_valid, out_ready;
  logic [WIDTH-1:0] out_inst_valid;
  logic [WIDTH*PW-1:0] out_psrc1, out_psrc2, out_pdst, out_pdst_old;
  logic [WIDTH-1:0] commit_valid;
  logic [WIDTH*5-1:0] commit_dst;
  logic [WIDTH*PW-1:0] commit_pdst, commit_pdst_old;
  logic flush;
  modport master (
    output in_valid, in_inst_valid, in_src1, in_src2, in_dst, out_ready,
           commit_valid, commit_dst, commit_pdst, commit_pdst_old, flush,
    input  in_ready, out_valid, out_inst_valid, out_psrc1, out_psrc2, out_pdst, out_pdst_old
  );
  modport slave (
    input  in_valid, in_inst_valid, in_src1, in_src2, in_dst, out_ready,
           commit_valid, commit_dst, commit_pdst, commit_pdst_old, flush,
    output in_ready, out_valid, out_inst_valid, out_psrc1, out_psrc2, out_pdst, out_pdst_old
  );
endinterface

// File: rtl/rename_unit.sv
// rename_unit: register renaming with speculative/committed RATs and a circular free list.
// Defining RENAME_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module rename_unit #(
  parameter int WIDTH = 2,
  parameter int AREG_NUM = 32,
  parameter int PREG_NUM = 64,
  localparam int PW = $clog2(PREG_NUM)
) (
  input logic clk,
  input logic reset,
  rename_if.slave bus
`ifdef RENAME_STALL_CNT_EN
  , output logic [31:0] stall_cnt
`endif
);
  logic [PW-1:0] r_spec_rat [AREG_NUM];
  logic [PW-1:0] r_cmt_rat [AREG_NUM];
  logic [PW-1:0] w_cmt_nxt [AREG_NUM];
  logic [PW-1:0] r_fl [PREG_NUM];
  logic [PW:0] r_head, r_tail, r_chead, w_free, w_need, w_ncmt;
  logic [PW-1:0] w_psrc1 [WIDTH];
  logic [PW-1:0] w_psrc2 [WIDTH];
  logic [PW-1:0] w_pdst [WIDTH];
  logic [PW-1:0] w_pold [WIDTH];
  logic [PW-1:0] w_fl_idx [WIDTH];
  logic [WIDTH-1:0] w_alloc, w_cmt;
  logic w_out_free, w_acc;
  logic r_out_valid;
  logic [WIDTH-1:0] r_out_iv;
  logic [WIDTH*PW-1:0] r_psrc1, r_psrc2, r_pdst, r_pold;

  assign w_free = r_tail - r_head;
  assign w_out_free = !r_out_valid || bus.out_ready;
  assign bus.in_ready = !bus.flush && w_out_free && w_free >= w_need;
  assign w_acc = bus.in_valid && bus.in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_inst_valid = r_out_iv;
  assign bus.out_psrc1 = r_psrc1;
  assign bus.out_psrc2 = r_psrc2;
  assign bus.out_pdst = r_pdst;
  assign bus.out_pdst_old = r_pold;

  // Older slots in the group override the RAT for younger readers.
  always_comb begin
    w_need = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_alloc[i] = bus.in_inst_valid[i] && bus.in_dst[i*5 +: 5] != 5'd0;
      w_pdst[i] = w_alloc[i] ? r_fl[r_head[PW-1:0] + w_need[PW-1:0]] : '0;
      w_psrc1[i] = r_spec_rat[bus.in_src1[i*5 +: 5]];
      w_psrc2[i] = r_spec_rat[bus.in_src2[i*5 +: 5]];
      w_pold[i] = r_spec_rat[bus.in_dst[i*5 +: 5]];
      for (int j = 0; j < i; j++) begin
        if (w_alloc[j] && bus.in_dst[j*5 +: 5] == bus.in_src1[i*5 +: 5]) w_psrc1[i] = w_pdst[j];
        if (w_alloc[j] && bus.in_dst[j*5 +: 5] == bus.in_src2[i*5 +: 5]) w_psrc2[i] = w_pdst[j];
        if (w_alloc[j] && bus.in_dst[j*5 +: 5] == bus.in_dst[i*5 +: 5]) w_pold[i] = w_pdst[j];
      end
      w_psrc1[i] = bus.in_inst_valid[i] && bus.in_src1[i*5 +: 5] != 5'd0 ? w_psrc1[i] : '0;
      w_psrc2[i] = bus.in_inst_valid[i] && bus.in_src2[i*5 +: 5] != 5'd0 ? w_psrc2[i] : '0;
      w_pold[i] = w_alloc[i] ? w_pold[i] : '0;
      w_need = w_need + (PW+1)'(w_alloc[i]);
    end
  end

  always_comb begin
    w_cmt_nxt = r_cmt_rat;
    w_ncmt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cmt[i] = bus.commit_valid[i] && bus.commit_dst[i*5 +: 5] != 5'd0;
      w_fl_idx[i] = r_tail[PW-1:0] + w_ncmt[PW-1:0];
      if (w_cmt[i]) w_cmt_nxt[bus.commit_dst[i*5 +: 5]] = bus.commit_pdst[i*PW +: PW];
      w_ncmt = w_ncmt + (PW+1)'(w_cmt[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < AREG_NUM; k++) begin
        r_spec_rat[k] <= PW'(k);
        r_cmt_rat[k] <= PW'(k);
      end
      for (int k = 0; k < PREG_NUM; k++) r_fl[k] <= PW'(AREG_NUM + k);
      r_head <= '0;
      r_chead <= '0;
      r_tail <= (PW+1)'(PREG_NUM - AREG_NUM);
    end else begin
      r_cmt_rat <= w_cmt_nxt;
      for (int i = 0; i < WIDTH; i++)
        if (w_cmt[i]) r_fl[w_fl_idx[i]] <= bus.commit_pdst_old[i*PW +: PW];
      r_tail <= r_tail + w_ncmt;
      r_chead <= r_chead + w_ncmt;
      if (bus.flush) begin
        r_spec_rat <= w_cmt_nxt;
        r_head <= r_chead + w_ncmt;
      end else if (w_acc) begin
        for (int i = 0; i < WIDTH; i++)
          if (w_alloc[i]) r_spec_rat[bus.in_dst[i*5 +: 5]] <= w_pdst[i];
        r_head <= r_head + w_need;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_iv <= '0;
      r_psrc1 <= '0;
      r_psrc2 <= '0;
      r_pdst <= '0;
      r_pold <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_iv <= bus.in_inst_valid;
      for (int i = 0; i < WIDTH; i++) begin
        r_psrc1[i*PW +: PW] <= w_psrc1[i];
        r_psrc2[i*PW +: PW] <= w_psrc2[i];
        r_pdst[i*PW +: PW] <= w_pdst[i];
        r_pold[i*PW +: PW] <= w_pold[i];
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef RENAME_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt <= '0;
    else if (bus.in_valid && !bus.flush && w_out_free && w_free < w_need && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

  assert property (@(posedge clk) disable iff (reset) w_free <= (PW+1)'(PREG_NUM - AREG_NUM + 1));
endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed and random stimulus for rename_unit, checked by a scoreboard fed
// from an in-order rename model (maps, free queue, ROB) of the architectural behaviour.
module tb_rename_unit;
  localparam int W = 2, A = 32, P = 64, PW = 6;
  typedef struct { logic [W-1:0] iv; logic [W*PW-1:0] p1, p2, pd, po; } exp_t;
  typedef struct { int dst, pdst, pold; } rob_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0, fails = 0;
  exp_t sbq[$];
  rob_t rob[$];
  int spec[A], cmt[A];
  int freeq[$], specq[$];
  logic ov;
  logic [31:0] stall_m;
`ifdef RENAME_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  rename_if #(.WIDTH(W), .PW(PW)) bus();
  rename_unit #(.WIDTH(W), .AREG_NUM(A), .PREG_NUM(P)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef RENAME_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [W*5-1:0] rregs();
    logic [W*5-1:0] r;
    for (int i = 0; i < W; i++) r[i*5 +: 5] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_inst_valid = '0;
    bus.in_src1 = '0;
    bus.in_src2 = '0;
    bus.in_dst = '0;
    bus.out_ready = 1'b1;
    bus.commit_valid = '0;
    bus.commit_dst = '0;
    bus.commit_pdst = '0;
    bus.commit_pdst_old = '0;
    bus.flush = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    for (int k = 0; k < A; k++) begin
      spec[k] = k;
      cmt[k] = k;
    end
    freeq.delete();
    specq.delete();
    rob.delete();
    sbq.delete();
    for (int k = A; k < P; k++) freeq.push_back(k);
    ov = 1'b0;
    stall_m = '0;
    @(negedge clk);
    #1;
    check("reset_outputs", {bus.out_valid, bus.out_inst_valid, bus.out_psrc1, bus.out_psrc2,
                            bus.out_pdst, bus.out_pdst_old}, '0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef RENAME_STALL_CNT_EN
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    reset = 1'b0;
  endtask

  task automatic step(input logic v, input logic [W-1:0] iv, input logic [W*5-1:0] s1, s2, d,
                      input logic ordy, input logic fl, input int ncm);
    int need, a1, a2, ad, pd, ncv;
    logic rdy, acc;
    exp_t e;
    rob_t cm[W];
    @(negedge clk);
    need = 0;
    for (int i = 0; i < W; i++) if (iv[i] && d[i*5 +: 5] != 5'd0) need++;
    rdy = !fl && (!ov || ordy) && freeq.size() >= need;
    acc = v && rdy;
    ncv = 0;
    bus.commit_valid = '0;
    bus.commit_dst = '0;
    bus.commit_pdst = '0;
    bus.commit_pdst_old = '0;
    for (int i = 0; i < W; i++)
      if (i < ncm && rob.size() > 0) begin
        cm[ncv] = rob.pop_front();
        bus.commit_valid[i] = 1'b1;
        bus.commit_dst[i*5 +: 5] = 5'(cm[ncv].dst);
        bus.commit_pdst[i*PW +: PW] = PW'(cm[ncv].pdst);
        bus.commit_pdst_old[i*PW +: PW] = PW'(cm[ncv].pold);
        ncv++;
      end
    bus.in_valid = v;
    bus.in_inst_valid = iv;
    bus.in_src1 = s1;
    bus.in_src2 = s2;
    bus.in_dst = d;
    bus.out_ready = ordy;
    bus.flush = fl;
    #1;
    check("in_ready", 64'(bus.in_ready), 64'(rdy));
`ifdef RENAME_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
    if (v && !fl && (!ov || ordy) && freeq.size() < need && stall_m != '1) stall_m++;
    if (acc) begin
      e.iv = iv;
      e.p1 = '0;
      e.p2 = '0;
      e.pd = '0;
      e.po = '0;
      for (int i = 0; i < W; i++)
        if (iv[i]) begin
          a1 = int'(s1[i*5 +: 5]);
          a2 = int'(s2[i*5 +: 5]);
          ad = int'(d[i*5 +: 5]);
          e.p1[i*PW +: PW] = PW'(a1 == 0 ? 0 : spec[a1]);
          e.p2[i*PW +: PW] = PW'(a2 == 0 ? 0 : spec[a2]);
          if (ad != 0) begin
            pd = freeq.pop_front();
            specq.push_back(pd);
            e.pd[i*PW +: PW] = PW'(pd);
            e.po[i*PW +: PW] = PW'(spec[ad]);
            rob.push_back('{ad, pd, spec[ad]});
            spec[ad] = pd;
          end
        end
      sbq.push_back(e);
    end
    for (int k = 0; k < ncv; k++) begin
      cmt[cm[k].dst] = cm[k].pdst;
      void'(specq.pop_front());
      freeq.push_back(cm[k].pold);
    end
    if (fl) begin
      if (ov && sbq.size() > 0) void'(sbq.pop_front());
      spec = cmt;
      freeq = {specq, freeq};
      specq.delete();
      rob.delete();
    end
    ov = fl ? 1'b0 : acc ? 1'b1 : ordy ? 1'b0 : ov;
  endtask

  task automatic step_idle();
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [W*PW-1:0] a1, a2, ad, ao;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && !bus.flush && bus.out_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got out_valid=1 expected no pending group at %0t", $time);
        end else begin
          e = bus.out_ready ? sbq.pop_front() : sbq[0];
          a1 = bus.out_psrc1;
          a2 = bus.out_psrc2;
          ad = bus.out_pdst;
          ao = bus.out_pdst_old;
          for (int i = 0; i < W; i++)
            if (!e.iv[i]) begin
              a1[i*PW +: PW] = '0; a2[i*PW +: PW] = '0; ad[i*PW +: PW] = '0; ao[i*PW +: PW] = '0;
              e.p1[i*PW +: PW] = '0; e.p2[i*PW +: PW] = '0; e.pd[i*PW +: PW] = '0; e.po[i*PW +: PW] = '0;
            end
          check(bus.out_ready ? "group" : "hold", {bus.out_inst_valid, a1, a2, ad, ao},
                {e.iv, e.p1, e.p2, e.pd, e.po});
        end
      end
    end
  end

  initial begin
    idle_inputs();
    apply_reset();
    step(1'b1, 2'b11, {5'd1, 5'd2}, {5'd1, 5'd3}, {5'd4, 5'd1}, 1'b1, 1'b0, 0);
    repeat (2) step_idle();
    apply_reset();
    step(1'b1, 2'b11, {5'd5, 5'd0}, {5'd0, 5'd0}, {5'd5, 5'd5}, 1'b1, 1'b0, 0);
    step(1'b1, 2'b01, {5'd0, 5'd5}, {5'd0, 5'd0}, {5'd0, 5'd0}, 1'b1, 1'b0, 0);
    repeat (2) step_idle();
    // Exhaust the free list, then stall until two registers return.
    apply_reset();
    repeat (16) step(1'b1, 2'b11, {5'd3, 5'd4}, {5'd1, 5'd2}, {5'd2, 5'd1}, 1'b1, 1'b0, 0);
    step(1'b1, 2'b11, {5'd1, 5'd2}, {5'd2, 5'd1}, {5'd0, 5'd0}, 1'b1, 1'b0, 0);
    repeat (2) step(1'b1, 2'b11, '0, '0, {5'd2, 5'd1}, 1'b1, 1'b0, 0);
    repeat (2) step(1'b1, 2'b11, '0, '0, {5'd2, 5'd1}, 1'b1, 1'b0, 1);
    step(1'b1, 2'b11, '0, '0, {5'd2, 5'd1}, 1'b1, 1'b0, 0);
    repeat (2) step_idle();
    apply_reset();
    repeat (3) step(1'b1, 2'b11, {5'd3, 5'd4}, {5'd1, 5'd3}, {5'd4, 5'd3}, 1'b1, 1'b0, 0);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 0);
    step(1'b1, 2'b01, {5'd0, 5'd3}, {5'd0, 5'd4}, {5'd0, 5'd6}, 1'b1, 1'b0, 0);
    step_idle();
    step(1'b1, 2'b01, {5'd0, 5'd6}, '0, {5'd0, 5'd7}, 1'b1, 1'b0, 0);
    repeat (3) step(1'b1, 2'b01, {5'd0, 5'd7}, '0, {5'd0, 5'd8}, 1'b0, 1'b0, 0);
    step(1'b1, 2'b01, {5'd0, 5'd8}, '0, {5'd0, 5'd9}, 1'b1, 1'b0, 0);
    repeat (2) step_idle();
    for (int n = 0; n < 500; n++)
      step(1'($urandom_range(0, 1)), W'($urandom), rregs(), rregs(), rregs(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, int'($urandom_range(0, 2)));
    repeat (4) step(1'b1, 2'b11, rregs(), rregs(), rregs(), 1'b0, 1'b0, 0);
    apply_reset();
    step(1'b1, 2'b11, {5'd1, 5'd2}, {5'd1, 5'd3}, {5'd4, 5'd1}, 1'b1, 1'b0, 0);
    repeat (3) step_idle();
    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rename_unit.md
RENAME_UNIT -- requirements
Module: rename_unit

Interface
REQ-001 Parameter WIDTH, default 2: instructions renamed per group.
REQ-002 Parameter AREG_NUM, default 32: architectural registers; x0 is hard-wired zero.
REQ-003 Parameter PREG_NUM, default 64: physical registers; PW = $clog2(PREG_NUM); PREG_NUM > AREG_NUM.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 in_valid  in  1 / in_ready  out  1  group handshake from decode.
REQ-007 in_inst_valid  in  WIDTH  per-slot valid; in_src1, in_src2, in_dst  in  WIDTH*5  architectural registers.
REQ-008 out_valid  out  1 / out_ready  in  1  group handshake to issue.
REQ-009 out_inst_valid  out  WIDTH; out_psrc1, out_psrc2, out_pdst, out_pdst_old  out  WIDTH*PW  renamed operands and the prior mapping of dst.
REQ-010 commit_valid  in  WIDTH; commit_dst  in  WIDTH*5; commit_pdst, commit_pdst_old  in  WIDTH*PW  in-order retirement, slot 0 oldest.
REQ-011 flush  in  1  discard all uncommitted speculative mappings.

Function
REQ-012 Internal state: speculative RAT, committed RAT, circular free list of depth PREG_NUM with (PW+1)-bit head, tail and commit_head pointers, and the registered output group.
REQ-013 Group accepted when in_valid && in_ready; in_ready = !flush && (!out_valid || out_ready) && free_count >= alloc_need.
REQ-014 alloc_need = number of slots with in_inst_valid && in_dst != 0; free_count = tail - head, computed before same-cycle commits.
REQ-015 Slots with dst != 0 take free-list entries head, head+1, ... in slot order; head advances by alloc_need.
REQ-016 psrcN of slot i = pdst of the highest older slot j < i with valid dst equal to srcN; otherwise the speculative RAT entry.
REQ-017 pdst_old of slot i uses the same override rule against dst.
REQ-018 src or dst of x0 always maps to preg 0; slots with dst x0 output pdst = 0 and pdst_old = 0 and allocate nothing.
REQ-019 Invalid slots allocate nothing, update nothing, and output out_inst_valid = 0.
REQ-020 Speculative RAT write on accept; the youngest slot wins on equal dst.
REQ-021 Latency is one cycle: an accepted group appears on the outputs with out_valid = 1 on the next edge.
REQ-022 Outputs hold stable while out_valid && !out_ready.
REQ-023 Commit, per valid slot with commit_dst != 0, in slot order: committed RAT[dst] <= commit_pdst; commit_pdst_old is pushed at tail; commit_head advances by one.
REQ-024 Registers freed at commit become allocatable in the next cycle.
REQ-025 On flush: speculative RAT <= committed RAT including same-cycle commits; head <= commit_head including same-cycle commits; out_valid <= 0; no accept that cycle; tail still advances with commits.
REQ-026 Pointer wrap is modulo PREG_NUM on the index, with the MSB as wrap bit; free_count never exceeds PREG_NUM - AREG_NUM + 1 (simulation assertion).

Reset
REQ-027 On reset: both RATs map i -> i; free list holds AREG_NUM..PREG_NUM-1 at indices 0..; head = commit_head = 0; tail = PREG_NUM - AREG_NUM.
REQ-028 On reset: out_valid = 0, all out_* = 0, and in_ready evaluates with the reset state.
REQ-029 Reset asserted mid-operation discards the in-flight group and all speculative and committed mappings.

Configuration
REQ-030 Macro RENAME_STALL_CNT_EN defined: output stall_cnt (32 bits) counts cycles with in_valid && !flush && output free && free_count < alloc_need; it saturates at all-ones and resets to 0.
REQ-031 Macro RENAME_STALL_CNT_EN undefined: stall_cnt port and counter are absent; all other behaviour is identical.

Verification (WIDTH=2, PREG_NUM=64)
REQ-032 After reset, group {x1<-x2,x3; x4<-x1,x1} -> next cycle slot0 psrc 2/3, pdst 32, old 1; slot1 psrc 32/32, pdst 33, old 4.
REQ-033 Group {x5<-x0,x0; x5<-x5,x0} -> slot1 psrc1 32, old 32, pdst 33; a later read of x5 returns 33.
REQ-034 Sixteen groups of two dst-writes, then a 17th -> in_ready=0 and stall_cnt increments; one commit (old 1) -> still stalled; second commit (old 2) -> accepted next cycle with pdst 1 and 2.
REQ-035 Three groups renamed, slot0 of the first committed, flush -> speculative RAT equals committed RAT; the next allocation returns preg 33.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged and in_ready=0; out_ready=1 -> a pending group is accepted the same cycle.
REQ-037 Group with both dst x0 and free_count=0 -> accepted; pdst=0; head unchanged.
